pipelined_cla_adder: RTL and testbench

- Parametrised, pipelined carry-lookahead adder/subtractor for the ALU datapath and multi-cycle units.
- Splits a WIDTH-bit operation into WIDTH/BLOCK lookahead blocks, one block per pipeline stage; the carry crosses a register between stages.
- Valid/ready handshake on both sides, an opaque tag carried alongside each operation, and word-level generate/propagate, overflow and zero flags.

---
 rtl/pipelined_cla_adder_pkg.sv | 13 +
 rtl/pipelined_cla_adder_if.sv | 36 +++
 rtl/pipelined_cla_adder_cla_block.sv | 39 +++
 rtl/pipelined_cla_adder.sv | 146 ++++++++++++++
 tb/tb_pipelined_cla_adder.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipelined_cla_adder_pkg.sv
// rtl/pipelined_cla_adder_pkg.sv - default sizing and stage-count helper for the pipelined CLA adder
package adder_pkg;

    localparam int ADDER_WIDTH = 32;
    localparam int ADDER_BLOCK = 8;
    localparam int ADDER_TAG_W = 5;

    // One lookahead block per pipeline stage; WIDTH must be a multiple of BLOCK.
    function automatic int adder_stages(input int width, input int block);
        return width / block;
    endfunction

endpackage

// File: rtl/pipelined_cla_adder_if.sv
// rtl/pipelined_cla_adder_if.sv - operation/result handshake bundle for the pipelined CLA adder
interface pipelined_cla_adder_if
    import adder_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH,
    parameter int TAG_W = ADDER_TAG_W
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             cin;
    logic [TAG_W-1:0] tag;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;
    logic             gen;
    logic             prop;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, a, b, sub, cin, tag, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero, gen, prop, out_tag
    );

    modport slave (
        input  in_valid, a, b, sub, cin, tag, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero, gen, prop, out_tag
    );

endinterface

// File: rtl/pipelined_cla_adder_cla_block.sv
// rtl/pipelined_cla_adder_cla_block.sv - combinational BLOCK-bit carry-lookahead slice
module cla_block #(
    parameter int BLOCK = 8
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             cin,
    output logic [BLOCK-1:0] s,
    output logic             cout,
    output logic             g_blk,
    output logic             p_blk,
    output logic             c_msb
);

    logic [BLOCK-1:0] g;
    logic [BLOCK-1:0] p;
    logic [BLOCK:0]   c;

    assign g = a & b;
    assign p = a | b;

    // Loop unrolls into the flat lookahead sum-of-products for every carry.
    always_comb begin
        c     = '0;
        c[0]  = cin;
        g_blk = 1'b0;
        p_blk = 1'b1;
        for (int i = 0; i < BLOCK; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
            g_blk  = g[i] | (p[i] & g_blk);
            p_blk  = p_blk & p[i];
        end
    end

    assign s     = a ^ b ^ c[BLOCK-1:0];
    assign cout  = c[BLOCK];
    assign c_msb = c[BLOCK-1];

endmodule

// File: rtl/pipelined_cla_adder.sv
// rtl/pipelined_cla_adder.sv - pipelined CLA adder/subtractor, one lookahead block per stage
// Build option: define ADDER_SAT_EN to clamp overflowing results to the signed extreme.
module pipelined_cla_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH,
    parameter int BLOCK = ADDER_BLOCK,
    parameter int TAG_W = ADDER_TAG_W
) (
    input logic                  clock,
    input logic                  reset_n,
    pipelined_cla_adder_if.slave bus
);

    localparam int STAGES = adder_stages(WIDTH, BLOCK);

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [WIDTH-1:0] a_rem;
        logic [WIDTH-1:0] b_rem;
        logic [WIDTH-1:0] sum_acc;
        logic             carry;
        logic             g;
        logic             p;
        logic             ovf;
    } stage_t;

    stage_t [STAGES-1:0] st;
    stage_t [STAGES-1:0] nxt;
    stage_t              entry;
    stage_t              last;
    logic                advance;

    logic             out_valid_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             zero_q;
    logic             gen_q;
    logic             prop_q;
    logic [TAG_W-1:0] tag_q;
    logic [WIDTH-1:0] res_sum;

    assign advance      = !out_valid_q || bus.out_ready;
    assign bus.in_ready = advance;

    // Operand B is inverted once at entry; later stages only ever see b'.
    always_comb begin
        entry         = '0;
        entry.valid   = bus.in_valid;
        entry.tag     = bus.tag;
        entry.a_rem   = bus.a;
        entry.b_rem   = bus.sub ? ~bus.b : bus.b;
        entry.carry   = bus.sub | bus.cin;
        entry.g       = 1'b0;
        entry.p       = 1'b1;
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        stage_t           src;
        stage_t           res;
        logic [BLOCK-1:0] blk_s;
        logic             blk_c;
        logic             blk_g;
        logic             blk_p;
        logic             blk_m;

        if (k == 0) begin : g_first
            assign src = entry;
        end else begin : g_next
            assign src = st[k-1];
        end

        cla_block #(.BLOCK(BLOCK)) u_cla (
            .a     (src.a_rem[k*BLOCK +: BLOCK]),
            .b     (src.b_rem[k*BLOCK +: BLOCK]),
            .cin   (src.carry),
            .s     (blk_s),
            .cout  (blk_c),
            .g_blk (blk_g),
            .p_blk (blk_p),
            .c_msb (blk_m)
        );

        // Running G/P compose with this block as the more significant half.
        always_comb begin
            res                           = src;
            res.sum_acc[k*BLOCK +: BLOCK] = blk_s;
            res.carry                     = blk_c;
            res.g                         = blk_g | (blk_p & src.g);
            res.p                         = blk_p & src.p;
            res.ovf                       = blk_m ^ blk_c;
        end

        assign nxt[k] = res;
    end

    assign last = st[STAGES-1];

`ifdef ADDER_SAT_EN
    always_comb begin
        res_sum = last.sum_acc;
        if (last.ovf) begin
            res_sum = last.a_rem[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                          : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign res_sum = last.sum_acc;
`endif

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            st          <= '0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            gen_q       <= 1'b0;
            prop_q      <= 1'b0;
            tag_q       <= '0;
        end else if (advance) begin
            st          <= nxt;
            out_valid_q <= last.valid;
            sum_q       <= res_sum;
            cout_q      <= last.carry;
            ovf_q       <= last.ovf;
            zero_q      <= (res_sum == '0);
            gen_q       <= last.g;
            prop_q      <= last.p;
            tag_q       <= last.tag;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;
    assign bus.gen       = gen_q;
    assign bus.prop      = prop_q;
    assign bus.out_tag   = tag_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// tb/tb_pipelined_cla_adder.sv - scoreboard bench for the pipelined CLA adder (32/8/5)
module tb_pipelined_cla_adder;

    localparam int LAT = 4;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
        logic        gen;
        logic        prop;
        logic [4:0]  tag;
        int          acc;
        bit          exact;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   exact_mode = 1'b1;
    bit   rnd_ready = 1'b0;
    logic fixed_ready = 1'b1;
    exp_t sb[$];

    pipelined_cla_adder_if #(.WIDTH(32), .TAG_W(5)) bus ();

    pipelined_cla_adder #(.WIDTH(32), .BLOCK(8), .TAG_W(5)) dut (
        .clock   (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain word-level arithmetic; G is the carry-out with cin forced to 0.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic s, input logic c, input logic [4:0] t);
        exp_t        r;
        logic [31:0] bb;
        logic [32:0] full;
        logic [32:0] nocin;
        bb    = s ? ~b : b;
        full  = {1'b0, a} + {1'b0, bb} + 33'(s | c);
        nocin = {1'b0, a} + {1'b0, bb};
        r.sum  = full[31:0];
        r.cout = full[32];
        r.ovf  = (a[31] == bb[31]) && (full[31] != a[31]);
`ifdef ADDER_SAT_EN
        if (r.ovf) r.sum = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
        r.zero  = (r.sum == 32'h0);
        r.gen   = nocin[32];
        r.prop  = &(a | bb);
        r.tag   = t;
        r.acc   = 0;
        r.exact = 1'b0;
        return r;
    endfunction

    task automatic step(input bit v, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic c, input logic [4:0] t,
                        input exp_t e, output bit taken);
        @(negedge clk);
        bus.in_valid  = v;
        bus.a         = a;
        bus.b         = b;
        bus.sub       = s;
        bus.cin       = c;
        bus.tag       = t;
        bus.out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : fixed_ready;
        #1;
        taken = v && bus.in_ready;
        if (taken) begin
            e.acc   = cyc + 1;
            e.exact = exact_mode;
            sb.push_back(e);
        end
    endtask

    task automatic idle();
        exp_t e;
        bit   tk;
        e = model(32'h0, 32'h0, 1'b0, 1'b0, 5'h0);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'h0, e, tk);
    endtask

    task automatic send_e(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic c, input logic [4:0] t, input exp_t e);
        bit tk;
        int n;
        n  = 0;
        tk = 1'b0;
        while (!tk && n < 50) begin
            step(1'b1, a, b, s, c, t, e, tk);
            n++;
        end
        if (!tk) check("accept_timeout", 64'(n), 64'd0);
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic c, input logic [4:0] t);
        send_e(a, b, s, c, t, model(a, b, s, c, t));
    endtask

    // Directed vectors: sum/cout/ovf/zero come from hand-worked constants.
    task automatic send_k(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic c, input logic [4:0] t, input logic [31:0] ksum,
                          input logic kcout, input logic kovf, input logic kzero);
        exp_t e;
        e      = model(a, b, s, c, t);
        e.sum  = ksum;
        e.cout = kcout;
        e.ovf  = kovf;
        e.zero = kzero;
        send_e(a, b, s, c, t, e);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            idle();
            n++;
        end
        check("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic check_quiet(input string pfx);
        check({pfx, "_out_valid"}, 64'(bus.out_valid), 64'd0);
        check({pfx, "_sum"},       64'(bus.sum),       64'd0);
        check({pfx, "_flags"},     64'({bus.cout, bus.ovf, bus.zero, bus.gen, bus.prop}), 64'd0);
        check({pfx, "_out_tag"},   64'(bus.out_tag),   64'd0);
        check({pfx, "_in_ready"},  64'(bus.in_ready),  64'd1);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_result_tag", 64'(bus.out_tag), 64'h1_0000);
                end else begin
                    e = sb.pop_front();
                    check("sum",  64'(bus.sum),  64'(e.sum));
                    check("cout", 64'(bus.cout), 64'(e.cout));
                    check("ovf",  64'(bus.ovf),  64'(e.ovf));
                    check("zero", 64'(bus.zero), 64'(e.zero));
                    check("gen",  64'(bus.gen),  64'(e.gen));
                    check("prop", 64'(bus.prop), 64'(e.prop));
                    check("tag",  64'(bus.out_tag), 64'(e.tag));
                    if (e.exact) check("latency", 64'(cyc - e.acc), 64'(LAT));
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [31:0] snap_sum;
        logic [4:0]  snap_tag;
        exp_t        e5;
        bit          tk;

        reset_n       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.sub       = 1'b0;
        bus.cin       = 1'b0;
        bus.tag       = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        #1;
        check_quiet("reset");

        // Plan vectors, no stalls: exact latency applies.
        send_k(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 5'd10, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
`ifdef ADDER_SAT_EN
        send_k(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 5'd11, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
`else
        send_k(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 5'd11, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
`endif
        send_k(32'd5, 32'd7, 1'b1, 1'b0, 5'd12, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        send_k(32'd7, 32'd5, 1'b1, 1'b0, 5'd13, 32'h0000_0002, 1'b1, 1'b0, 1'b0);
        send_k(32'h1234_5678, 32'h0, 1'b1, 1'b0, 5'd14, 32'h1234_5678, 1'b1, 1'b0, 1'b0);
        send_k(32'h1234_5678, 32'h0, 1'b1, 1'b1, 5'd15, 32'h1234_5678, 1'b1, 1'b0, 1'b0);
        send_k(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b1, 5'd16, 32'h0000_0031, 1'b0, 1'b0, 1'b0);
        drain();

        // Back-to-back tags 1..4 with in_ready held high.
        for (int i = 1; i <= 4; i++) begin
            send(32'(i * 1000), 32'(i * 3), 1'b0, 1'b0, 5'(i));
            check("b2b_in_ready", 64'(bus.in_ready), 64'd1);
        end
        drain();

        // Fill with out_ready low, then hold the stall for three cycles.
        exact_mode  = 1'b0;
        fixed_ready = 1'b0;
        for (int i = 1; i <= 4; i++) send($urandom, $urandom, 1'(i & 1), 1'b1, 5'(20 + i));
        idle();
        e5 = model(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0, 1'b1, 5'd25);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0, 1'b1, 5'd25, e5, tk);
            if (i == 0) begin
                snap_sum = bus.sum;
                snap_tag = bus.out_tag;
            end
            check("stall_in_ready",  64'(bus.in_ready),  64'd0);
            check("stall_out_valid", 64'(bus.out_valid), 64'd1);
            check("stall_sum_hold",  64'(bus.sum),       64'(snap_sum));
            check("stall_tag_hold",  64'(bus.out_tag),   64'(snap_tag));
        end
        fixed_ready = 1'b1;
        send_e(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0, 1'b1, 5'd25, e5);
        drain();

        // Randomized traffic with random back-pressure and input gaps.
        rnd_ready = 1'b1;
        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 4) == 0) idle();
            send(pick(), pick(), 1'($urandom), 1'($urandom), 5'($urandom));
        end
        rnd_ready = 1'b0;
        drain();

        // Reset with three operations in flight; none may resurface.
        exact_mode = 1'b1;
        for (int i = 0; i < 3; i++) send($urandom, $urandom, 1'b0, 1'b0, 5'(i + 1));
        @(negedge clk);
        reset_n      = 1'b0;
        bus.in_valid = 1'b0;
        sb.delete();
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check_quiet("post_reset");
        repeat (6) idle();
        send(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 5'd31);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
